two_by_two: RTL and testbench
=============================

TWO_BY_TWO -- requirements
Module: two_by_two

Interface
- REQ-001 SHALL have no parameters; element width fixed at 8 bits unsigned, matrix size fixed at 2x2.
- REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-004 SHALL have port data1, input, 32 bits: matrix A, packed {a11,a12,a21,a22}, a11 in [31:24], a22 in [7:0].
- REQ-005 SHALL have port data2, input, 32 bits: matrix B, packed {b11,b12,b21,b22}, same packing as data1.
- REQ-006 SHALL have port in_valid, input, 1 bit: operands on data1/data2 are valid.
- REQ-007 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
- REQ-008 SHALL have port out, output, 32 bits: product C = A x B, packed {c11,c12,c21,c22}, same packing as data1.
- REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a new result on out.
- REQ-010 SHALL have port ovf, output, 1 bit: some element of the last result exceeded 255.

Function
- REQ-011 SHALL compute the elements as:
  - c11 = a11*b11 + a12*b21
  - c12 = a11*b12 + a12*b22
  - c21 = a21*b11 + a22*b21
  - c22 = a21*b12 + a22*b22
- REQ-012 SHALL carry every sum at a full 17 bits internally (max 130050), with no intermediate truncation.
- REQ-013 SHALL, by default, store each output element as the low 8 bits of its full sum (modulo 256).
- REQ-014 SHALL implement an FSM with states IDLE, CALC (element index 0..3) and DONE.
- REQ-015 SHALL drive in_ready = 1 only in IDLE.
- REQ-016 SHALL, on an edge with in_valid=1 in IDLE, latch data1 and data2 into internal registers, clear the index and go to CALC.
- REQ-017 SHALL ignore in_valid and any data1/data2 changes in CALC and DONE; the latched operands alone define the result.
- REQ-018 SHALL, in CALC, compute one element per edge in order c11, c12, c21, c22 into an internal result buffer.
- REQ-019 SHALL, on the edge that computes c22, load out and ovf from the complete buffer in one update, set out_valid=1, and go to DONE.
- REQ-020 SHALL, in DONE, clear out_valid on the next edge and return to IDLE, so out_valid is high for exactly one cycle.
- REQ-021 SHALL give a latency of 4 edges from the accept edge to the edge that raises out_valid, with at least one idle cycle before the next accept (throughput 1 result per 6 cycles).
- REQ-022 SHALL hold out and ovf stable between completions; they change only on a completion edge or on reset.
- REQ-023 SHALL set ovf on a completion if any of the four full sums is greater than 255, and clear it otherwise.

Reset
- REQ-024 SHALL, with rst=1 on an edge, force: state IDLE, index 0, out=0, out_valid=0, ovf=0, operand and buffer registers 0.
- REQ-025 SHALL, on reset mid-operation (CALC or DONE), abort the operation; no out_valid pulse is produced for it.
- REQ-026 SHALL give rst priority over a simultaneous in_valid; no accept happens on a reset edge.
- REQ-027 SHALL have in_ready=1 in the first cycle after reset is released.

Configuration
- REQ-028 SHALL, with macro TWO_BY_TWO_SAT_EN defined, saturate each element whose full sum exceeds 255 to 8'hFF instead of wrapping; ovf behaves identically.
- REQ-029 SHALL, without TWO_BY_TWO_SAT_EN, use modulo-256 wrapping as in REQ-013.

Verification
- REQ-030 SHALL cover: reset asserted -> out=0x00000000, out_valid=0, ovf=0, in_ready=1.
- REQ-031 SHALL cover: data1=0x01020304, data2=0x05060708, in_valid pulse -> out_valid 4 edges later, out=0x13162B32 ([19 22; 43 50]), ovf=0.
- REQ-032 SHALL cover: data1=0x01000001 (identity), data2=0xAABBCCDD -> out=0xAABBCCDD, ovf=0.
- REQ-033 SHALL cover: data1=data2=0xFFFFFFFF -> out=0x02020202, ovf=1; with TWO_BY_TWO_SAT_EN -> out=0xFFFFFFFF, ovf=1.
- REQ-034 SHALL cover: new data1/data2 and in_valid=1 during CALC -> ignored, result matches the first operands; then rst at CALC index 2 -> no out_valid, outputs 0, next accept gives a correct result.
- REQ-035 SHALL cover: in_valid held high continuously -> one accept per 6 cycles, one out_valid pulse per accept, in_ready low except in IDLE.

Source files
------------

// File: rtl/two_by_two.sv
// two_by_two: sequential 2x2 unsigned 8-bit matrix multiplier, one element per clock.
// Define TWO_BY_TWO_SAT_EN to saturate overflowing elements to 8'hFF instead of wrapping.
module two_by_two (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, next_state;
  logic [1:0]  idx;
  logic [31:0] opa, opb;
  logic [23:0] res_buf;
  logic [2:0]  ovf_buf;
  logic [7:0]  a1, a2, b1, b2;
  logic [16:0] sum;
  logic [7:0]  elem;
  logic        elem_ovf;
  logic        accept, last;

  assign accept = in_ready && in_valid;
  assign last   = (state == CALC) && (idx == 2'd3);

  // idx[1] picks the row of A, idx[0] the column of B: 0=c11, 1=c12, 2=c21, 3=c22
  always_comb begin
    a1 = idx[1] ? opa[15:8]  : opa[31:24];
    a2 = idx[1] ? opa[7:0]   : opa[23:16];
    b1 = idx[0] ? opb[23:16] : opb[31:24];
    b2 = idx[0] ? opb[7:0]   : opb[15:8];
  end

  assign sum      = ({9'd0, a1} * {9'd0, b1}) + ({9'd0, a2} * {9'd0, b2});
  assign elem_ovf = |sum[16:8];

`ifdef TWO_BY_TWO_SAT_EN
  assign elem = elem_ovf ? 8'hFF : sum[7:0];
`else
  assign elem = sum[7:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = CALC;
      end
      CALC:    if (idx == 2'd3) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final element bypasses the buffer so out and ovf update together on the last CALC edge
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 2'd0;
      opa       <= 32'd0;
      opb       <= 32'd0;
      res_buf   <= 24'd0;
      ovf_buf   <= 3'd0;
      out       <= 32'd0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= last;
      if (accept) begin
        opa <= data1;
        opb <= data2;
        idx <= 2'd0;
      end else if (state == CALC) begin
        idx <= idx + 2'd1;
        case (idx)
          2'd0: begin res_buf[23:16] <= elem; ovf_buf[2] <= elem_ovf; end
          2'd1: begin res_buf[15:8]  <= elem; ovf_buf[1] <= elem_ovf; end
          2'd2: begin res_buf[7:0]   <= elem; ovf_buf[0] <= elem_ovf; end
          default: begin
            out <= {res_buf, elem};
            ovf <= (|ovf_buf) | elem_ovf;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_two_by_two.sv
// tb_two_by_two: randomized self-checking bench for two_by_two against a matrix-level model.
// Honours TWO_BY_TWO_SAT_EN the same way as the design.
module tb_two_by_two;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] data1 = 32'd0;
  logic [31:0] data2 = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        ovf;

  int checks   = 0;
  int failures = 0;

  logic [31:0] last_out = 32'd0;
  logic        last_ovf = 1'b0;

  two_by_two dut (
    .clk       (clk),
    .rst       (rst),
    .data1     (data1),
    .data2     (data2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Plain matrix product on integers; returns {ovf, packed C}
  function automatic logic [32:0] model(input logic [31:0] d1, input logic [31:0] d2);
    int a [2][2];
    int b [2][2];
    int s;
    logic [31:0] c;
    logic        o;
    c = 32'd0;
    o = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        a[i][j] = int'(d1[31 - 8*(2*i + j) -: 8]);
        b[i][j] = int'(d2[31 - 8*(2*i + j) -: 8]);
      end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = a[i][0] * b[0][j] + a[i][1] * b[1][j];
        if (s > 255) o = 1'b1;
`ifdef TWO_BY_TWO_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        c[31 - 8*(2*i + j) -: 8] = 8'(s);
      end
    return {o, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; with disturb set, in_valid and operands are scrambled while busy
  task automatic applyStimulus(input logic [31:0] d1, input logic [31:0] d2, input bit disturb);
    logic [32:0] exp;
    exp = model(d1, d2);
    @(negedge clk);
    checkOutput("ready_idle", 32'(in_ready), 32'd1);
    data1    = d1;
    data2    = d2;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int e = 0; e < 4; e++) begin
      in_valid = disturb;
      if (disturb) begin
        data1 = $urandom;
        data2 = $urandom;
      end
      checkOutput("busy_ready", 32'(in_ready), 32'd0);
      checkOutput("early_valid", 32'(out_valid), 32'd0);
      checkOutput("out_hold", out, last_out);
      checkOutput("ovf_hold", 32'(ovf), 32'(last_ovf));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("valid_pulse", 32'(out_valid), 32'd1);
    checkOutput("result", out, exp[31:0]);
    checkOutput("ovf", 32'(ovf), 32'(exp[32]));
    checkOutput("done_ready", 32'(in_ready), 32'd0);
    last_out = exp[31:0];
    last_ovf = exp[32];
    @(posedge clk);
    @(negedge clk);
    checkOutput("valid_clear", 32'(out_valid), 32'd0);
    checkOutput("result_hold", out, last_out);
    checkOutput("ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d1, d2;
    logic [32:0] exp;
    int pulses;

    // Reset with in_valid high: reset must win, no accept
    in_valid = 1'b1;
    data1    = 32'h01020304;
    data2    = 32'h05060708;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_out", out, 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ovf", 32'(ovf), 32'd0);
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    rst      = 1'b0;
    in_valid = 1'b0;
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);

    applyStimulus(32'h01020304, 32'h05060708, 1'b0);
    applyStimulus(32'h01000001, 32'hAABBCCDD, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    applyStimulus(32'h01020304, 32'h05060708, 1'b1);

    // Reset at CALC index 2 aborts the operation
    @(negedge clk);
    data1    = 32'h11223344;
    data2    = 32'h55667788;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_out", out, 32'd0);
    checkOutput("abort_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_ovf", 32'(ovf), 32'd0);
    rst      = 1'b0;
    last_out = 32'd0;
    last_ovf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkOutput("abort_no_pulse", 32'(out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(32'h02030405, 32'h06070809, 1'b0);

    // Randomized transactions, some with small operands so ovf can be clear
    for (int n = 0; n < 24; n++) begin
      d1 = $urandom;
      d2 = $urandom;
      if (n % 3 == 0) begin
        d1 = d1 & 32'h0B0B0B0B;
        d2 = d2 & 32'h0B0B0B0B;
      end
      applyStimulus(d1, d2, (n % 4) == 1);
    end

    // in_valid held high: accept every 6 cycles, pulse 5 cycles after each accept
    @(negedge clk);
    d1       = 32'h0A0B0C0D;
    d2       = 32'h01020304;
    exp      = model(d1, d2);
    data1    = d1;
    data2    = d2;
    in_valid = 1'b1;
    pulses   = 0;
    for (int k = 0; k < 36; k++) begin
      checkOutput("stream_ready", 32'(in_ready), 32'((k % 6) == 0));
      checkOutput("stream_valid", 32'(out_valid), 32'((k % 6) == 5));
      if (out_valid) begin
        pulses++;
        checkOutput("stream_result", out, exp[31:0]);
        checkOutput("stream_ovf", 32'(ovf), 32'(exp[32]));
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("stream_pulses", 32'(pulses), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
